// File: rtl/mips_pkg.sv
// Shared types and constants for the pipeline hazard sequencer.
package mips_pkg;
    localparam int COUNTERWIDTH     = 32;
    localparam int DRAIN_CYCLES_DEF = 3;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        STALL  = 2'd1,
        DRAIN  = 2'd2,
        HALTED = 2'd3
    } seqState_e;

    // A distance of 3 can never need more than two bubbles.
    function automatic logic [1:0] clamp_dist(input logic [1:0] d);
        return (d == 2'd3) ? 2'd2 : d;
    endfunction
endpackage

// File: rtl/sat_counter.sv
// Event counter that sticks at all-ones instead of wrapping.
module sat_counter
    import mips_pkg::*;
#(
    parameter logic [COUNTERWIDTH-1:0] INIT = '0
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    en,
    output logic [COUNTERWIDTH-1:0] count
);
    logic [COUNTERWIDTH-1:0] count_q;
    logic [COUNTERWIDTH-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (en && (count_q != '1)) begin
            count_d = count_q + COUNTERWIDTH'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= INIT;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;
endmodule

// File: rtl/pipe_sequencer.sv
// Stall / flush / halt-drain sequencer for a five-stage pipeline.
module pipe_sequencer
    import mips_pkg::*;
#(
    parameter bit                      FORWARD_EN   = 1'b1,
    parameter int                      DRAIN_CYCLES = DRAIN_CYCLES_DEF,
    parameter logic [COUNTERWIDTH-1:0] STAT_INIT    = '0
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    hazard,
    input  logic [1:0]              hazardDist,
    input  logic                    loadUse,
    input  logic                    branchTaken,
    input  logic                    haltSignal,
    output logic                    pcWrite,
    output logic                    ifIdWrite,
    output logic                    ifIdFlush,
    output logic                    idExBubble,
    output logic                    haltDone,
    output logic [COUNTERWIDTH-1:0] stallCycles,
    output logic [COUNTERWIDTH-1:0] hazardEvents,
    output logic [COUNTERWIDTH-1:0] flushEvents
);
    localparam int CW = (DRAIN_CYCLES > 3) ? $clog2(DRAIN_CYCLES + 1) : 2;

    seqState_e state_q;
    seqState_e state_d;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    logic [1:0] stall_n;
    logic       in_run;
    logic       in_stall;
    logic       flush_ev;
    logic       stall_ev;
    logic       halt_ev;
    logic       stall_cyc;

    assign stall_n = FORWARD_EN ? {1'b0, loadUse} : clamp_dist(hazardDist);
    assign in_run   = reset && (state_q == RUN);
    assign in_stall = reset && (state_q == STALL);

    assign flush_ev  = branchTaken && (in_run || in_stall);
    assign stall_ev  = in_run && !branchTaken && hazard && (stall_n != 2'd0);
    assign halt_ev   = in_run && !branchTaken && !stall_ev && haltSignal;
    assign stall_cyc = stall_ev || (in_stall && !branchTaken);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            RUN: begin
                if (flush_ev) begin
                    cnt_d = '0;
                end else if (stall_ev) begin
                    cnt_d = CW'(stall_n) - CW'(1);
                    if (stall_n == 2'd2) begin
                        state_d = STALL;
                    end
                end else if (halt_ev) begin
                    cnt_d   = CW'(DRAIN_CYCLES);
                    state_d = (DRAIN_CYCLES > 0) ? DRAIN : HALTED;
                end
            end
            STALL: begin
                if (flush_ev) begin
                    cnt_d   = '0;
                    state_d = RUN;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                    if (cnt_q <= CW'(1)) begin
                        state_d = RUN;
                    end
                end
            end
            DRAIN: begin
                cnt_d = cnt_q - CW'(1);
                if (cnt_q <= CW'(1)) begin
                    state_d = HALTED;
                end
            end
            HALTED: begin
                cnt_d = '0;
            end
            default: begin
                state_d = RUN;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= RUN;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Mealy outputs; reset overrides everything back to free-running.
    always_comb begin
        pcWrite    = 1'b1;
        ifIdWrite  = 1'b1;
        ifIdFlush  = 1'b0;
        idExBubble = 1'b0;
        if (flush_ev) begin
            ifIdFlush  = 1'b1;
            idExBubble = 1'b1;
        end else if (stall_cyc || halt_ev ||
                     (reset && (state_q == DRAIN)) ||
                     (reset && (state_q == HALTED))) begin
            pcWrite    = 1'b0;
            ifIdWrite  = 1'b0;
            idExBubble = 1'b1;
        end
    end

    assign haltDone = reset && (state_q == HALTED);

    sat_counter #(.INIT(STAT_INIT)) u_stall_cnt (
        .clk   (clk),
        .rst_n (reset),
        .en    (stall_cyc),
        .count (stallCycles)
    );

    sat_counter #(.INIT(STAT_INIT)) u_hazard_cnt (
        .clk   (clk),
        .rst_n (reset),
        .en    (stall_ev),
        .count (hazardEvents)
    );

    sat_counter #(.INIT(STAT_INIT)) u_flush_cnt (
        .clk   (clk),
        .rst_n (reset),
        .en    (flush_ev),
        .count (flushEvents)
    );
endmodule

// File: doc/pipe_sequencer.md
PIPE_SEQUENCER -- requirements
Module: pipe_sequencer

Interface
REQ-001 SHALL have parameter FORWARD_EN, default 1; 1 means the forwarding datapath is present, 0 means all RAW hazards are resolved by stalling.
REQ-002 SHALL have parameter DRAIN_CYCLES, default 3; the number of cycles needed for EX, MEM and WB to retire after a halt reaches ID.
REQ-003 SHALL have ports, one per line: name, direction, width, meaning:
- clk  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- hazard  in  1  RAW dependency detected for the instruction in ID.
- hazardDist  in  2  stall cycles needed without forwarding; range 0..2.
- loadUse  in  1  the hazard source is a load in EX.
- branchTaken  in  1  a branch resolved taken in EX this cycle.
- haltSignal  in  1  the instruction in ID is HALT.
- pcWrite  out  1  PC register load enable.
- ifIdWrite  out  1  IF/ID register load enable.
- ifIdFlush  out  1  clear IF/ID to a NOP.
- idExBubble  out  1  load a NOP into ID/EX instead of the decoded control.
- haltDone  out  1  pipeline fully drained after HALT; sticky.
- stallCycles  out  32  saturating count of stall cycles.
- hazardEvents  out  32  saturating count of stall-causing hazards.
- flushEvents  out  32  saturating count of taken-branch flushes.

Function
REQ-004 SHALL implement the FSM states RUN, STALL, DRAIN and HALTED.
REQ-005 SHALL apply event priority within a cycle as follows: branchTaken, then stall-causing hazard, then haltSignal.
REQ-006 SHALL compute stall length N for a hazard in RUN as follows:
- FORWARD_EN=1: N = 1 if loadUse, otherwise 0.
- FORWARD_EN=0: N = hazardDist.
- hazardDist=3: treat as 2.
REQ-007 SHALL treat a hazard with N=0 as no event: no stall and no count.
REQ-008 SHALL drive control outputs combinationally from the state and current inputs (Mealy), so a stall or flush takes effect in the same cycle the event is presented.
REQ-009 SHALL drive the following in RUN with no event: pcWrite=1, ifIdWrite=1, ifIdFlush=0, idExBubble=0.
REQ-010 SHALL, for a stall-causing hazard in RUN in cycle T:
- drive pcWrite=0, ifIdWrite=0 and idExBubble=1 in cycle T;
- load the remaining-stall counter with N-1;
- go to STALL if N-1>0, otherwise stay in RUN;
- produce exactly N consecutive stall cycles in total.
REQ-011 SHALL, in STALL:
- hold the stall outputs;
- decrement the counter each cycle;
- return to RUN after the cycle in which the counter equals 1;
- ignore hazard and haltSignal.
REQ-012 SHALL, for branchTaken in RUN or STALL:
- drive ifIdFlush=1, idExBubble=1, pcWrite=1 and ifIdWrite=1 in that cycle;
- abort any stall: clear the counter and go to RUN;
- drop a simultaneous hazard or halt.
REQ-013 SHALL, for haltSignal in RUN with no higher-priority event in cycle T:
- drive pcWrite=0, ifIdWrite=0 and idExBubble=1 from cycle T on;
- load the drain counter with DRAIN_CYCLES;
- enter DRAIN.
REQ-014 SHALL, in DRAIN:
- keep pcWrite=0, ifIdWrite=0 and idExBubble=1;
- ignore all inputs;
- decrement the drain counter each cycle;
- go to HALTED after the cycle in which the counter equals 1.
REQ-015 SHALL, in HALTED:
- drive haltDone=1 and pcWrite=ifIdWrite=0 with idExBubble=1;
- leave HALTED only on reset.
- For default DRAIN_CYCLES, haltDone first rises at T+4.
REQ-016 SHALL increment stallCycles by one in every cycle with pcWrite=0 caused by a stall (not drain or halt).
REQ-017 SHALL increment hazardEvents once per stall-causing hazard and flushEvents once per taken-branch flush.
REQ-018 SHALL saturate all counters at 32'hFFFF_FFFF, with no wrap-around.

Reset
REQ-019 SHALL, while reset=0 (asynchronously):
- force state=RUN, all internal counters=0, haltDone=0 and stallCycles=hazardEvents=flushEvents=0;
- drive control outputs to their RUN values: pcWrite=1, ifIdWrite=1, ifIdFlush=0, idExBubble=0.
REQ-020 SHALL, on reset asserted mid-STALL or mid-DRAIN, abandon the sequence immediately, with no residual stall after deassertion.

Structure
REQ-021 SHALL have the enum seqState_e (RUN, STALL, DRAIN, HALTED) and constants COUNTERWIDTH=32 and DRAIN_CYCLES_DEF=3 defined in mips_pkg and imported.
REQ-022 SHALL implement the three statistics counters as three instances of one sub-module, sat_counter (enable in, COUNTERWIDTH-bit count out, async active-low reset).

Verification
REQ-023 SHALL pass the following directed scenarios:
- Load-use stall: FORWARD_EN=1, hazard=1, loadUse=1 at T -> pcWrite=0 at T only; hazardEvents=1; stallCycles=1.
- Hazard without forwarding: FORWARD_EN=0, hazard=1, hazardDist=2 at T -> pcWrite=0 at T and T+1, RUN at T+2; stallCycles=2.
- Branch aborts stall: FORWARD_EN=0, hazardDist=2 at T, branchTaken=1 at T+1 -> ifIdFlush=1 and pcWrite=1 at T+1; RUN at T+2; stallCycles=1; flushEvents=1.
- Branch beats halt: haltSignal=1 and branchTaken=1 at T -> flush only, no DRAIN; haltDone=0 at T+5.
- Halt drain: haltSignal=1 at T -> pcWrite=0 from T on; haltDone=1 at T+4 and held; a later hazard=1 has no effect on stallCycles.
- Reset mid-drain and saturation: reset=0 at T+2 of a drain -> haltDone=0 and pcWrite=1 immediately; counter preloaded to 32'hFFFF_FFFE with two stall cycles -> reads 32'hFFFF_FFFF.
